// File: rtl/i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// i2c_slave_responder : I2C target engine, fixed 7-bit address, ACKs writes,
//                       streams read bytes until the master NACKs. Rev 1.0
// ============================================================================
module i2c_slave_responder #(
  parameter int                  ADDR_LEN    = 7,
  parameter int                  DATA_LEN    = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  input  logic                sda_in,
  output logic                sda_oe,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_req,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                rw,
  output logic                busy,
  output logic [3:0]          state_slave
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    RX_BYTE  = 4'd3,
    RX_ACK   = 4'd4,
    TX_BYTE  = 4'd5,
    TX_ACK   = 4'd6
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_LEN);
  localparam logic [3:0] PRE_LAST = 4'(DATA_LEN - 1);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_prev, sda_prev;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;

  // Bus pins idle high, so every synchronizer stage resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_s    <= 1'b1;
      sda_s    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_s    <= scl_sync[SYNC_STAGES-1];
      sda_s    <= sda_sync[SYNC_STAGES-1];
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;
  assign start_ev = scl_s & ~sda_s & sda_prev;
  assign stop_ev  = scl_s & sda_s & ~sda_prev;

  state_t              state, state_n;
  logic [DATA_LEN-1:0] shift, shift_n, shift_in, rx_data_n;
  logic [3:0]          bit_cnt, bit_cnt_n;
  logic                rw_n, rx_valid_n, tx_req_n, sda_oe_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      rw       <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      sda_oe   <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      rw       <= rw_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      sda_oe   <= sda_oe_n;
    end
  end

  assign shift_in = {shift[DATA_LEN-2:0], sda_s};

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    rw_n       = rw;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    sda_oe_n   = sda_oe;

    if (start_ev) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_ev) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise && bit_cnt != LAST_BIT) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == PRE_LAST) begin
              if (shift_in[DATA_LEN-1 -: ADDR_LEN] == SLAVE_ADDR) rw_n = shift_in[0];
              else                                                 state_n = IDLE;
            end
          end else if (scl_fall && bit_cnt == LAST_BIT) begin
            sda_oe_n = 1'b1;
            state_n  = ADDR_ACK;
          end
        end
        // Both ACK phases for reads leave by loading the next byte and driving its MSB.
        ADDR_ACK, TX_ACK: begin
          if (state == TX_ACK && scl_rise && sda_s) begin
            state_n = IDLE;
          end else if (scl_fall) begin
            bit_cnt_n = '0;
            if (state == TX_ACK || rw) begin
              shift_n  = tx_data;
              tx_req_n = 1'b1;
              sda_oe_n = ~tx_data[DATA_LEN-1];
              state_n  = TX_BYTE;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = RX_BYTE;
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise && bit_cnt != LAST_BIT) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == PRE_LAST) begin
              rx_data_n  = shift_in;
              rx_valid_n = 1'b1;
            end
          end else if (scl_fall && bit_cnt == LAST_BIT) begin
            sda_oe_n = 1'b1;
            state_n  = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = RX_BYTE;
          end
        end
        TX_BYTE: begin
          if (scl_rise && bit_cnt != LAST_BIT) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == LAST_BIT) begin
            sda_oe_n = 1'b0;
            state_n  = TX_ACK;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            // Bit being presented always sits just below the MSB of the shifter.
            sda_oe_n = ~shift[DATA_LEN-2];
            shift_n  = {shift[DATA_LEN-2:0], 1'b0};
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign state_slave = state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// tb_i2c_slave_responder : directed bus-master bench for i2c_slave_responder.
// Rev 1.0
// ============================================================================
module tb_i2c_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  wire        sda_in;
  logic       sda_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw;
  logic       busy;
  logic [3:0] state_slave;

  int vectors = 0;
  int miscompares = 0;
  int oe_cycles = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;

  // Open-drain wired-AND of master and target.
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_responder #(
    .ADDR_LEN(7), .DATA_LEN(8), .SLAVE_ADDR(7'h50), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .rw(rw), .busy(busy), .state_slave(state_slave)
  );

  always @(posedge clk) begin
    if (sda_oe)   oe_cycles <= oe_cycles + 1;
    if (rx_valid) rx_cnt    <= rx_cnt + 1;
    if (tx_req)   tx_cnt    <= tx_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    sda_m = 1'b1; tick(4);
    scl = 1'b1;   tick(4);
    sda_m = 1'b0; tick(4);
    scl = 1'b0;   tick(4);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; tick(4);
    scl = 1'b1;   tick(4);
    sda_m = 1'b1; tick(8);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;  tick(4);
    scl = 1'b1; tick(8);
    scl = 1'b0; tick(4);
  endtask

  task automatic get_bit(output logic b, output logic oe);
    sda_m = 1'b1; tick(4);
    scl = 1'b1;   tick(4);
    b = sda_in;
    oe = sda_oe;
    tick(4);
    scl = 1'b0;   tick(4);
  endtask

  task automatic put_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
  endtask

  task automatic get_byte(output logic [7:0] v);
    logic b, oe;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      get_bit(b, oe);
      v = {v[6:0], b};
    end
  endtask

  initial begin
    logic       ack, oe;
    logic [7:0] rd;
    int rx0, tx0, oe0;

    // Reset state
    tick(3);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_tx_req", tx_req, 1'b0);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rw", rw, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_state", state_slave, 4'd0);
    rst_n = 1'b1;
    tick(3);

    // Write 0xA5 to 0x50
    rx0 = rx_cnt;
    do_start();
    check("wr_busy_after_start", busy, 1'b1);
    check("wr_state_addr", state_slave, 4'd1);
    put_byte(8'hA0);
    get_bit(ack, oe);
    check("wr_addr_ack", ack, 1'b0);
    check("wr_addr_ack_oe", oe, 1'b1);
    put_byte(8'hA5);
    get_bit(ack, oe);
    check("wr_data_ack", ack, 1'b0);
    check("wr_data_ack_oe", oe, 1'b1);
    check("wr_rx_pulses", rx_cnt - rx0, 1);
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_rw", rw, 1'b0);
    do_stop();
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_state_after_stop", state_slave, 4'd0);

    // Write to 0x51: address mismatch
    rx0 = rx_cnt;
    oe0 = oe_cycles;
    do_start();
    put_byte(8'hA2);
    get_bit(ack, oe);
    check("mis_no_ack", ack, 1'b1);
    check("mis_state_idle", state_slave, 4'd0);
    put_byte(8'h5A);
    do_stop();
    check("mis_oe_never", oe_cycles - oe0, 0);
    check("mis_no_rx", rx_cnt - rx0, 0);
    check("mis_final_state", state_slave, 4'd0);

    // Read two bytes from 0x50: ACK the first, NACK the second
    tx_data = 8'h3C;
    tx0 = tx_cnt;
    do_start();
    put_byte(8'hA1);
    get_bit(ack, oe);
    check("rd_addr_ack", ack, 1'b0);
    check("rd_rw", rw, 1'b1);
    get_byte(rd);
    check("rd_byte0", rd, 8'h3C);
    tx_data = 8'hC3;
    put_bit(1'b0);
    get_byte(rd);
    check("rd_byte1", rd, 8'hC3);
    put_bit(1'b1);
    check("rd_nack_state", state_slave, 4'd0);
    check("rd_nack_oe", sda_oe, 1'b0);
    check("rd_tx_pulses", tx_cnt - tx0, 2);
    do_stop();

    // Repeated START after 4 data bits, then read from 0x50
    rx0 = rx_cnt;
    do_start();
    put_byte(8'hA0);
    get_bit(ack, oe);
    check("rs_wr_ack", ack, 1'b0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    tx_data = 8'h81;
    do_start();
    check("rs_state_addr", state_slave, 4'd1);
    put_byte(8'hA1);
    get_bit(ack, oe);
    check("rs_rd_ack", ack, 1'b0);
    check("rs_rd_ack_oe", oe, 1'b1);
    check("rs_rw", rw, 1'b1);
    check("rs_no_rx", rx_cnt - rx0, 0);
    get_byte(rd);
    check("rs_rd_byte", rd, 8'h81);
    put_bit(1'b1);
    do_stop();

    // STOP after 5 bits of a write
    rx0 = rx_cnt;
    do_start();
    put_byte(8'hA0);
    get_bit(ack, oe);
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b0); put_bit(1'b1);
    do_stop();
    check("stop5_state", state_slave, 4'd0);
    check("stop5_oe", sda_oe, 1'b0);
    check("stop5_no_rx", rx_cnt - rx0, 0);

    // Reset during ADDR_ACK, then a full write still works
    do_start();
    put_byte(8'hA0);
    tick(2);
    check("rst_in_addr_ack_state", state_slave, 4'd2);
    check("rst_in_addr_ack_oe", sda_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_oe", sda_oe, 1'b0);
    check("rst_async_state", state_slave, 4'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    rx0 = rx_cnt;
    do_start();
    put_byte(8'hA0);
    get_bit(ack, oe);
    check("post_rst_addr_ack", ack, 1'b0);
    put_byte(8'h5A);
    get_bit(ack, oe);
    check("post_rst_data_ack", ack, 1'b0);
    check("post_rst_rx_pulses", rx_cnt - rx0, 1);
    check("post_rst_rx_data", rx_data, 8'h5A);
    do_stop();
    check("post_rst_state", state_slave, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
